// File: rtl/vga_timing_pkg.sv
// Shared types and constants for the VGA raster timing generator:
// per-axis phase encoding, a timing description record and the
// standard 640x480@60 horizontal/vertical timing.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } timing_t;

  localparam timing_t VGA_640x480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam timing_t VGA_640x480_V = '{active: 480, fp: 10, sync: 2,  bp: 33};

  // Total period of one axis, in pixels or lines.
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus a four-phase
// decoder (active, front porch, sync, back porch). The counter and the
// phase advance together on every clk where inc is high.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int  ACTIVE = 640,
  parameter int  FP     = 16,
  parameter int  SYNC   = 96,
  parameter int  BP     = 48,
  parameter bit  POL    = 1'b0,
  localparam int TOTAL  = axis_total(ACTIVE, FP, SYNC, BP),
  localparam int W      = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count,
  output phase_e       phase,
  output logic         sync,
  output logic         wrap
);

  // A zero-length region would collapse two phase boundaries into one.
  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_region
    $error("vga_axis_counter: every timing region must be at least 1");
  end

  // Last position of each phase, at counter width.
  localparam logic [W-1:0] ACTIVE_END = W'(ACTIVE - 1);
  localparam logic [W-1:0] FRONT_END  = W'(ACTIVE + FP - 1);
  localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC - 1);
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);

  // Position counter and phase FSM, stepped together so phase always matches count.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      count <= '0;
      phase <= PH_ACTIVE;
    end else if (inc) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
      case (phase)
        PH_ACTIVE: if (count == ACTIVE_END) phase <= PH_FRONT;
        PH_FRONT:  if (count == FRONT_END)  phase <= PH_SYNC;
        PH_SYNC:   if (count == SYNC_END)   phase <= PH_BACK;
        PH_BACK:   if (count == LAST)       phase <= PH_ACTIVE;
        default:                            phase <= PH_ACTIVE;
      endcase
    end
  end

  assign wrap = inc && (count == LAST);
  assign sync = (phase == PH_SYNC) ? POL : !POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/raster timing generator. Horizontal and vertical
// axis counters are advanced by pix_en; the vertical axis steps on each
// horizontal wrap. Defining VGA_TIMING_REGOUT_EN adds one output
// register stage (all outputs delayed exactly one clk, mutually aligned).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int  H_ACTIVE   = VGA_640x480_H.active,
  parameter int  H_FP       = VGA_640x480_H.fp,
  parameter int  H_SYNC     = VGA_640x480_H.sync,
  parameter int  H_BP       = VGA_640x480_H.bp,
  parameter int  V_ACTIVE   = VGA_640x480_V.active,
  parameter int  V_FP       = VGA_640x480_V.fp,
  parameter int  V_SYNC     = VGA_640x480_V.sync,
  parameter int  V_BP       = VGA_640x480_V.bp,
  parameter bit  H_SYNC_POL = 1'b0,
  parameter bit  V_SYNC_POL = 1'b0,
  localparam int H_TOTAL    = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL    = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW         = $clog2(H_TOTAL),
  localparam int VW         = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  phase_e        h_phase, v_phase;
  logic          h_sync_lvl, v_sync_lvl;
  logic          h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_SYNC_POL)
  ) u_h_axis (
    .clk   (clk),
    .reset (reset),
    .inc   (pix_en),
    .count (h_cnt),
    .phase (h_phase),
    .sync  (h_sync_lvl),
    .wrap  (h_wrap)
  );

  // The frame boundary is recognised from the counters, so the vertical wrap is not needed.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_SYNC_POL)
  ) u_v_axis (
    .clk   (clk),
    .reset (reset),
    .inc   (h_wrap),
    .count (v_cnt),
    .phase (v_phase),
    .sync  (v_sync_lvl),
    .wrap  ()
  );

  // Decoded (unregistered) view of the raster position.
  logic active_c, line_c, frame_c;
  assign active_c = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
  assign line_c   = pix_en && (h_cnt == '0);
  assign frame_c  = line_c && (v_cnt == '0);

`ifdef VGA_TIMING_REGOUT_EN
  // Output register stage, loaded every clk so all outputs stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync       <= !H_SYNC_POL;
      vsync       <= !V_SYNC_POL;
      active      <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= h_sync_lvl;
      vsync       <= v_sync_lvl;
      active      <= active_c;
      x           <= h_cnt;
      y           <= v_cnt;
      line_start  <= line_c;
      frame_start <= frame_c;
    end
  end
`else
  assign hsync       = h_sync_lvl;
  assign vsync       = v_sync_lvl;
  assign active      = active_c;
  assign x           = h_cnt;
  assign y           = v_cnt;
  assign line_start  = line_c;
  assign frame_start = frame_c;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen with small timing
// (H 8/2/3/1 -> 14, V 4/1/2/1 -> 8, active-low syncs). The reference
// model tracks the raster position with plain integers and derives each
// output from the region boundaries. With VGA_TIMING_REGOUT_EN defined
// the expected values are the same model delayed by one clk.
module tb_vga_timing_gen;

  localparam int H_A = 8, H_F = 2, H_S = 3, H_B = 1;
  localparam int V_A = 4, V_F = 1, V_S = 2, V_B = 1;
  localparam int HT = H_A + H_F + H_S + H_B;
  localparam int VT = V_A + V_F + V_S + V_B;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pix_en = 1'b0;
  logic       hsync, vsync, active, line_start, frame_start;
  logic [3:0] x;
  logic [2:0] y;

  vga_timing_gen #(
    .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
    .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hsync(hsync), .vsync(vsync), .active(active),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hs, vs, act;
    logic [3:0] px;
    logic [2:0] py;
    logic       ls, fs;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   mx = 0, my = 0;
  bit   mvalid = 1'b0;
  exp_t e_reg = '0;
  bit   e_reg_valid = 1'b0;

  // Expected outputs for raster position (px, py) with the given pix_en.
  function automatic exp_t ref_out(input int px, input int py, input bit pen);
    exp_t r;
    r.hs  = !(px >= H_A + H_F && px < H_A + H_F + H_S);
    r.vs  = !(py >= V_A + V_F && py < V_A + V_F + V_S);
    r.act = (px < H_A) && (py < V_A);
    r.px  = 4'(px);
    r.py  = 3'(py);
    r.ls  = pen && (px == 0);
    r.fs  = pen && (px == 0) && (py == 0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clk: drive inputs after the falling edge, check outputs, then step the model.
  task automatic cycle(input bit pen, input bit rst);
    exp_t e;
    bit   v;
    @(negedge clk);
    pix_en = pen;
    reset  = rst;
    #1;
`ifdef VGA_TIMING_REGOUT_EN
    e = e_reg;
    v = e_reg_valid;
`else
    e = ref_out(mx, my, pen);
    v = mvalid;
`endif
    if (v) begin
      chk("hsync",       32'(hsync),       32'(e.hs));
      chk("vsync",       32'(vsync),       32'(e.vs));
      chk("active",      32'(active),      32'(e.act));
      chk("x",           32'(x),           32'(e.px));
      chk("y",           32'(y),           32'(e.py));
      chk("line_start",  32'(line_start),  32'(e.ls));
      chk("frame_start", 32'(frame_start), 32'(e.fs));
    end
`ifdef VGA_TIMING_REGOUT_EN
    if (rst) e_reg = '{hs: 1'b1, vs: 1'b1, act: 1'b0, px: 4'd0, py: 3'd0, ls: 1'b0, fs: 1'b0};
    else     e_reg = ref_out(mx, my, pen);
    e_reg_valid = rst || mvalid;
`endif
    if (rst) begin
      mx = 0;
      my = 0;
      mvalid = 1'b1;
    end else if (pen && mvalid) begin
      mx = mx + 1;
      if (mx == HT) begin
        mx = 0;
        my = (my + 1) % VT;
      end
    end
  endtask

  initial begin
    int last;
    int act_cnt;

    // Reset, then continuous pix_en: line_start period is one line.
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    last = -1;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b1, 1'b0);
      if (line_start === 1'b1) begin
        if (last >= 0) chk("line_period", 32'(i - last), 32'(HT));
        last = i;
      end
    end

    // Two more frames at full rate: frame_start period is one frame.
    last = -1;
    for (int i = 0; i < 2 * HT * VT + 4; i++) begin
      cycle(1'b1, 1'b0);
      if (frame_start === 1'b1) begin
        if (last >= 0) chk("frame_period", 32'(i - last), 32'(HT * VT));
        last = i;
      end
    end

    // Active cycles in one full frame at full rate.
    act_cnt = 0;
    for (int i = 0; i < HT * VT; i++) begin
      cycle(1'b1, 1'b0);
      if (active === 1'b1) act_cnt++;
    end
    chk("active_per_frame", 32'(act_cnt), 32'(H_A * V_A));

    // pix_en toggling 1,0: frame period doubles.
    last = -1;
    for (int i = 0; i < 2 * 2 * HT * VT + 8; i++) begin
      cycle(i[0] == 1'b0, 1'b0);
      if (frame_start === 1'b1) begin
        if (last >= 0) chk("frame_period_half_rate", 32'(i - last), 32'(2 * HT * VT));
        last = i;
      end
    end

    // Reset mid-frame at (6,3), then frame_start on the first pix_en.
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 3 * HT + 6; i++) cycle(1'b1, 1'b0);
    chk("model_pos_before_reset", 32'(mx * 16 + my), 32'(6 * 16 + 3));
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
`ifdef VGA_TIMING_REGOUT_EN
    cycle(1'b0, 1'b0);
`endif
    chk("frame_start_after_reset", 32'(frame_start), 32'd1);

    // Random pix_en with occasional resets.
    for (int i = 0; i < 800; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
